// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce/edge-detect block: FSM state encoding
// and the sizing rule for the debounce counter.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        WAIT_HI = 2'd1,
        ST_HI   = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    // One spare bit above clog2 so DEBOUNCE_CYCLES-1 always fits, including
    // the degenerate DEBOUNCE_CYCLES=1 case where clog2 returns 0.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/debounce_edge_if.sv
// Signal bundle between a raw pin source and the debouncer: raw level in,
// debounced level/complement and edge pulses out.
interface debounce_edge_if;

    logic din;
    logic level;
    logic level_n;
    logic rise;
    logic fall;

    modport master (
        output din,
        input  level,
        input  level_n,
        input  rise,
        input  fall
    );

    modport slave (
        input  din,
        output level,
        output level_n,
        output rise,
        output fall
    );

endinterface

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; every stage clears
// on the asynchronous reset so no stale value survives a reset pulse.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stage_reg;
    logic [SYNC_STAGES-1:0] stage_next;

    assign stage_next[0] = d;

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_link
            assign stage_next[gi] = stage_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Debounced level with rise/fall pulses: a new synchronized value is accepted
// only after it has held for DEBOUNCE_CYCLES cycles beyond the first sighting.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    debounce_edge_if.slave  bus
);

    localparam int                CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_s;
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             level_n_reg;
    logic             rise_reg;
    logic             fall_reg;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.din),
        .q   (sync_s)
    );

    // Pulses default low every cycle so each accepted edge lasts exactly one
    // clock; the stable states need at least one cycle before a new WAIT can
    // complete, which keeps pulses from ever landing back to back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_LO;
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            level_n_reg <= 1'b1;
            rise_reg    <= 1'b0;
            fall_reg    <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            case (state_reg)
                ST_LO: begin
                    level_reg   <= 1'b0;
                    level_n_reg <= 1'b1;
                    if (sync_s) begin
                        state_reg <= WAIT_HI;
                        cnt_reg   <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!sync_s) begin
                        state_reg <= ST_LO;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_MAX) begin
                        state_reg   <= ST_HI;
                        cnt_reg     <= '0;
                        level_reg   <= 1'b1;
                        level_n_reg <= 1'b0;
                        rise_reg    <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_HI: begin
                    level_reg   <= 1'b1;
                    level_n_reg <= 1'b0;
                    if (!sync_s) begin
                        state_reg <= WAIT_LO;
                        cnt_reg   <= '0;
                    end
                end
                WAIT_LO: begin
                    if (sync_s) begin
                        state_reg <= ST_HI;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_MAX) begin
                        state_reg   <= ST_LO;
                        cnt_reg     <= '0;
                        level_reg   <= 1'b0;
                        level_n_reg <= 1'b1;
                        fall_reg    <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_LO;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.level   = level_reg;
    assign bus.level_n = level_n_reg;
    assign bus.rise    = rise_reg;
    assign bus.fall    = fall_reg;

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: directed scenarios plus random din, all compared
// against a run-length model of "new value held for DEBOUNCE_CYCLES+1 edges".
module tb_debounce_edge;
    import debounce_pkg::*;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    debounce_edge_if bus ();

    debounce_edge #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: din delayed by SYNC_STAGES edges, then a count of
    // consecutive edges disagreeing with the accepted level.
    logic pipe [SYNC_STAGES];
    logic m_level;
    logic m_rise;
    logic m_fall;
    int   run;

    task automatic model_reset();
        for (int i = 0; i < SYNC_STAGES; i++) pipe[i] = 1'b0;
        m_level = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        run     = 0;
    endtask

    task automatic model_edge(input logic d);
        logic s;
        s = pipe[SYNC_STAGES-1];
        for (int i = SYNC_STAGES - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = d;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s != m_level) begin
            run = run + 1;
            if (run == DEBOUNCE_CYCLES + 1) begin
                m_level = s;
                run     = 0;
                if (s) m_rise = 1'b1;
                else   m_fall = 1'b1;
            end
        end else begin
            run = 0;
        end
    endtask

    function automatic logic [3:0] obs();
        return {bus.level, bus.level_n, bus.rise, bus.fall};
    endfunction

    function automatic logic [3:0] exp_out();
        return {m_level, ~m_level, m_rise, m_fall};
    endfunction

    // Drive din, advance one clock, update the model, settle past the edge.
    task automatic step(input logic d);
        bus.din = d;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(d);
        #1;
    endtask

    task automatic settle(input logic d, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(d);
            checks++;
            if (obs() !== exp_out()) begin
                errors++;
                $display("FAIL %s settle %0d: {lvl,lvl_n,rise,fall} got %b exp %b", tag, i, obs(), exp_out());
            end
        end
    endtask

    task automatic test_reset();
        int e0;
        e0 = errors;
        bus.din = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs() !== 4'b0100) begin
            errors++;
            $display("FAIL reset_async: got %b exp %b", obs(), 4'b0100);
        end
        for (int i = 0; i < 8; i++) begin
            bus.din = ~bus.din;
            #5;
            checks++;
            if (obs() !== 4'b0100) begin
                errors++;
                $display("FAIL reset_hold %0d: got %b exp %b", i, obs(), 4'b0100);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        settle(1'b0, 4, "reset");
        $display("test_reset: %0d errors", errors - e0);
    endtask

    task automatic test_rise_latency();
        int e0;
        int first;
        int n;
        e0 = errors; first = -1; n = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1);
            checks++;
            if (obs() !== exp_out()) begin
                errors++;
                $display("FAIL rise step %0d: got %b exp %b", i, obs(), exp_out());
            end
            if (bus.rise === 1'b1) begin
                n++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (first != LAT) begin
            errors++;
            $display("FAIL rise_latency: got edge %0d exp %0d", first, LAT);
        end
        checks++;
        if (n != 1 || bus.level !== 1'b1 || bus.level_n !== 1'b0) begin
            errors++;
            $display("FAIL rise_once: pulses %0d level %b level_n %b exp 1/1/0", n, bus.level, bus.level_n);
        end
        $display("test_rise_latency: rise at edge %0d, %0d errors", first, errors - e0);
    endtask

    task automatic test_fall_latency();
        int e0;
        int first;
        int nf;
        int nr;
        e0 = errors; first = -1; nf = 0; nr = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0);
            checks++;
            if (obs() !== exp_out()) begin
                errors++;
                $display("FAIL fall step %0d: got %b exp %b", i, obs(), exp_out());
            end
            if (bus.rise === 1'b1) nr++;
            if (bus.fall === 1'b1) begin
                nf++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (first != LAT || nf != 1 || nr != 0) begin
            errors++;
            $display("FAIL fall_latency: edge %0d falls %0d rises %0d exp %0d/1/0", first, nf, nr, LAT);
        end
        checks++;
        if (bus.level !== 1'b0 || bus.level_n !== 1'b1) begin
            errors++;
            $display("FAIL fall_level: level %b level_n %b exp 0/1", bus.level, bus.level_n);
        end
        $display("test_fall_latency: fall at edge %0d, %0d errors", first, errors - e0);
    endtask

    task automatic test_glitch();
        int e0;
        int nr;
        e0 = errors;
        for (int w = 3; w <= 5; w++) begin
            nr = 0;
            settle(1'b0, 12, "glitch_pre");
            for (int i = 0; i < w + 10; i++) begin
                step(i < w ? 1'b1 : 1'b0);
                checks++;
                if (obs() !== exp_out()) begin
                    errors++;
                    $display("FAIL glitch w=%0d step %0d: got %b exp %b", w, i, obs(), exp_out());
                end
                if (bus.rise === 1'b1) nr++;
            end
            checks++;
            if (nr != ((w > DEBOUNCE_CYCLES) ? 1 : 0)) begin
                errors++;
                $display("FAIL glitch_width w=%0d: rises %0d exp %0d", w, nr, (w > DEBOUNCE_CYCLES) ? 1 : 0);
            end
            if (w == 3) begin
                checks++;
                if (dut.state_reg !== ST_LO) begin
                    errors++;
                    $display("FAIL glitch_state: got %0d exp %0d", dut.state_reg, ST_LO);
                end
            end
        end
        $display("test_glitch: widths 3..5, %0d errors", errors - e0);
    endtask

    task automatic test_reset_mid();
        int e0;
        int first;
        int n;
        e0 = errors; first = -1; n = 0;
        settle(1'b0, 14, "midrst_pre");
        settle(1'b1, 5, "midrst_wait");
        checks++;
        if (dut.cnt_reg !== 3'd2) begin
            errors++;
            $display("FAIL midrst_cnt: got %0d exp 2", dut.cnt_reg);
        end
        #4;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs() !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_async: got %b exp %b", obs(), 4'b0100);
        end
        settle(1'b1, 2, "midrst_hold");
        #8;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1);
            checks++;
            if (obs() !== exp_out()) begin
                errors++;
                $display("FAIL midrst step %0d: got %b exp %b", i, obs(), exp_out());
            end
            if (bus.rise === 1'b1) begin
                n++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (first != LAT || n != 1) begin
            errors++;
            $display("FAIL midrst_release: rise edge %0d count %0d exp %0d/1", first, n, LAT);
        end
        $display("test_reset_mid: rise at edge %0d after release, %0d errors", first, errors - e0);
    endtask

    task automatic test_bounce();
        int e0;
        int first;
        int n;
        logic [4:0] pat;
        e0 = errors; first = -1; n = 0;
        pat = 5'b01101;
        settle(1'b0, 14, "bounce_pre");
        for (int i = 0; i < 20; i++) begin
            step(i < 5 ? pat[i] : 1'b1);
            checks++;
            if (obs() !== exp_out()) begin
                errors++;
                $display("FAIL bounce step %0d: got %b exp %b", i, obs(), exp_out());
            end
            if (bus.rise === 1'b1) begin
                n++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (n != 1 || first != 5 + LAT) begin
            errors++;
            $display("FAIL bounce_rise: count %0d edge %0d exp 1/%0d", n, first, 5 + LAT);
        end
        $display("test_bounce: rise at edge %0d, %0d errors", first, errors - e0);
    endtask

    task automatic test_random();
        int   e0;
        int   left;
        int   nr;
        int   nf;
        logic v;
        logic prev_pulse;
        e0 = errors; left = 0; nr = 0; nf = 0; v = bus.din; prev_pulse = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (left == 0) begin
                v    = ~v;
                left = $urandom_range(1, 9);
            end
            left--;
            step(v);
            checks++;
            if (obs() !== exp_out()) begin
                errors++;
                $display("FAIL random step %0d din %b: got %b exp %b", i, v, obs(), exp_out());
            end
            checks++;
            if ((bus.rise === 1'b1 || bus.fall === 1'b1) && prev_pulse) begin
                errors++;
                $display("FAIL random_pulse_gap step %0d: rise %b fall %b after pulse", i, bus.rise, bus.fall);
            end
            prev_pulse = bus.rise | bus.fall;
            if (bus.rise === 1'b1) nr++;
            if (bus.fall === 1'b1) nf++;
            if ($urandom_range(0, 79) == 0) begin
                #4;
                rst = 1'b1;
                model_reset();
                #1;
                checks++;
                if (obs() !== 4'b0100) begin
                    errors++;
                    $display("FAIL random_rst step %0d: got %b exp %b", i, obs(), 4'b0100);
                end
                #3;
                rst = 1'b0;
                prev_pulse = 1'b0;
            end
        end
        $display("test_random: 500 steps, %0d rises %0d falls, %0d errors", nr, nf, errors - e0);
    endtask

    initial begin
        bus.din = 1'b0;
        model_reset();
        test_reset();
        test_rise_latency();
        test_fall_latency();
        test_glitch();
        test_reset_mid();
        test_bounce();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
